// File: rtl/vi_debounce_ctrl.sv
// vi_debounce_ctrl: multi-channel input debouncer with shared sample prescaler,
// per-channel saturating hysteresis counters, edge events, sticky W1C status
// and a maskable level interrupt.
// Optional build macro VI_DEBOUNCE_CTRL_GLITCH_CNT_EN adds glitch_cnt, an
// 8-bit saturating per-channel count of counter direction reversals.
// status_clr is a write-one-to-clear pulse vector with no handshake: any bit
// high in a cycle clears that status bit (and glitch field) at the next edge,
// unless a new event sets the bit in that same cycle.
module vi_debounce_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 2,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_raw,
    input  logic             cfg_enable,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [N-1:0]     irq_mask,
    input  logic [N-1:0]     status_clr,
    output logic [N-1:0]     debounced,
    output logic [N-1:0]     rise_evt,
    output logic [N-1:0]     fall_evt,
    output logic [N-1:0]     status,
    output logic             irq
`ifdef VI_DEBOUNCE_CTRL_GLITCH_CNT_EN
   ,output logic [N*8-1:0]   glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [N-1:0]     sync1;
    logic [N-1:0]     in_s;
    logic [DIV_W-1:0] pcnt;
    logic             tick;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];
    logic [N-1:0]     deb_next;

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            in_s  <= '0;
        end else begin
            sync1 <= in_raw;
            in_s  <= sync1;
        end
    end

    // The >= compare lets a shrinking cfg_div tick immediately instead of wrapping.
    assign tick = cfg_enable && (pcnt >= cfg_div);

    // Shared prescaler; held at zero while sampling is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!cfg_enable || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Saturating counter step and hysteresis decision, only on a sample tick.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = cnt[i];
            deb_next[i] = debounced[i];
            if (tick) begin
                if (in_s[i] && (cnt[i] != MAX)) begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end else if (!in_s[i] && (cnt[i] != '0)) begin
                    cnt_next[i] = cnt[i] - 1'b1;
                end
                if (cnt_next[i] == MAX) begin
                    deb_next[i] = 1'b1;
                end else if (cnt_next[i] == '0) begin
                    deb_next[i] = 1'b0;
                end
            end
        end
    end

    // Channel state, edge events, sticky status (set beats clear) and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
            debounced <= '0;
            rise_evt  <= '0;
            fall_evt  <= '0;
            status    <= '0;
            irq       <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
            debounced <= deb_next;
            rise_evt  <= deb_next & ~debounced;
            fall_evt  <= ~deb_next & debounced;
            status    <= (status & ~status_clr) | rise_evt | fall_evt;
            irq       <= |(status & irq_mask);
        end
    end

`ifdef VI_DEBOUNCE_CTRL_GLITCH_CNT_EN
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    dir_t dir [N];

    // Track last tick's direction; count a reversal while cnt sits strictly inside (0, MAX).
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                dir[i]             <= DIR_NONE;
                glitch_cnt[i*8 +: 8] <= '0;
            end else begin
                if (tick) begin
                    if (cnt_next[i] > cnt[i]) begin
                        dir[i] <= DIR_UP;
                    end else if (cnt_next[i] < cnt[i]) begin
                        dir[i] <= DIR_DOWN;
                    end else begin
                        dir[i] <= DIR_NONE;
                    end
                end
                if (status_clr[i]) begin
                    glitch_cnt[i*8 +: 8] <= '0;
                end else if (tick && (cnt[i] != MAX) && (cnt[i] != '0) &&
                             (glitch_cnt[i*8 +: 8] != 8'hFF) &&
                             (((dir[i] == DIR_UP) && (cnt_next[i] < cnt[i])) ||
                              ((dir[i] == DIR_DOWN) && (cnt_next[i] > cnt[i])))) begin
                    glitch_cnt[i*8 +: 8] <= glitch_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vi_debounce_ctrl.sv
// Directed bench for vi_debounce_ctrl with N=4, CNT_W=2. Expected values are
// hand-derived cycle counts from the prescaler phase (cyc counts edges after
// reset release).
module tb_vi_debounce_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     in_raw;
    logic             cfg_enable;
    logic [DIV_W-1:0] cfg_div;
    logic [N-1:0]     irq_mask;
    logic [N-1:0]     status_clr;
    logic [N-1:0]     debounced;
    logic [N-1:0]     rise_evt;
    logic [N-1:0]     fall_evt;
    logic [N-1:0]     status;
    logic             irq;
`ifdef VI_DEBOUNCE_CTRL_GLITCH_CNT_EN
    logic [N*8-1:0]   glitch_cnt;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   cyc0;
    int   f0;
    logic found;
    logic bad;

    vi_debounce_ctrl #(.N(N), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_raw     (in_raw),
        .cfg_enable (cfg_enable),
        .cfg_div    (cfg_div),
        .irq_mask   (irq_mask),
        .status_clr (status_clr),
        .debounced  (debounced),
        .rise_evt   (rise_evt),
        .fall_evt   (fall_evt),
        .status     (status),
        .irq        (irq)
`ifdef VI_DEBOUNCE_CTRL_GLITCH_CNT_EN
       ,.glitch_cnt (glitch_cnt)
`endif
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_raw     = '0;
        cfg_enable = 1'b1;
        cfg_div    = 16'd3;
        irq_mask   = 4'b0001;
        status_clr = '0;
        repeat (3) step();
        check("reset_debounced", 32'(debounced), 32'h0);
        check("reset_rise", 32'(rise_evt), 32'h0);
        check("reset_fall", 32'(fall_evt), 32'h0);
        check("reset_status", 32'(status), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        // Clean rising step on ch0: 2 sync clk + 3 ticks at edges 4, 8, 12.
        reset     = 1'b0;
        in_raw[0] = 1'b1;
        cyc       = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (debounced[0]) break;
        end
        check("rise_latency", 32'(cyc), 32'd12);
        check("rise_evt_pulse", 32'(rise_evt), 32'h1);
        check("status_before_set", 32'(status), 32'h0);
        step();
        check("rise_evt_one_cycle", 32'(rise_evt), 32'h0);
        check("status_set", 32'(status), 32'h1);
        check("irq_lag", 32'(irq), 32'h0);
        step();
        check("irq_set", 32'(irq), 32'h1);

        // ch1 high across exactly one tick: counter 1 then 0, no output change.
        bad       = 1'b0;
        in_raw[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) in_raw[1] = 1'b0;
            step();
            bad |= debounced[1] | rise_evt[1] | fall_evt[1];
        end
        check("short_pulse_ignored", 32'(bad), 32'h0);
`ifdef VI_DEBOUNCE_CTRL_GLITCH_CNT_EN
        check("glitch_cnt_ch1", 32'(glitch_cnt[15:8]), 32'h1);
`endif

        // ch0 low across one tick: 3->2->3, debounced holds by hysteresis.
        bad       = 1'b0;
        in_raw[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) in_raw[0] = 1'b1;
            step();
            bad |= ~debounced[0] | fall_evt[0] | rise_evt[0];
        end
        check("hysteresis_hold", 32'(bad), 32'h0);

        // Fresh fall on ch0 with a simultaneous clear: set wins.
        in_raw[0] = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fall_evt[0]) begin
                found = 1'b1;
                break;
            end
        end
        check("fall_seen", 32'(found), 32'h1);
        check("fall_debounced", 32'(debounced), 32'h0);
        status_clr = 4'b0001;
        step();
        check("status_set_wins", 32'(status), 32'h1);
        check("fall_evt_one_cycle", 32'(fall_evt), 32'h0);
        step();
        check("status_cleared", 32'(status), 32'h0);
        check("irq_still_high", 32'(irq), 32'h1);
        status_clr = 4'b0000;
        step();
        check("irq_cleared", 32'(irq), 32'h0);

        // Prescaler: div 1000 from pcnt 0, run 500, shrink to 10 -> ticks at +501, +512, +523.
        while (cyc % 4 != 0) step();
        cyc0      = cyc;
        cfg_div   = 16'd1000;
        in_raw[2] = 1'b1;
        repeat (500) step();
        cfg_div = 16'd10;
        while (cyc < cyc0 + 522) step();
        check("div_shrink_pre", 32'(debounced), 32'h0);
        step();
        check("div_shrink_deb", 32'(debounced), 32'h4);
        check("div_shrink_rise", 32'(rise_evt), 32'h4);
        step();
        check("status_ch2", 32'(status), 32'h4);
        step();
        check("irq_masked", 32'(irq), 32'h0);

        // Freeze for 50 cycles with toggling inputs.
        cfg_enable = 1'b0;
        bad        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            in_raw = (i < 46) ? 4'($urandom_range(0, 15)) : 4'b0001;
            step();
            bad |= (debounced != 4'b0100) | (status != 4'b0100) | (|rise_evt) | (|fall_evt);
        end
        check("freeze_hold", 32'(bad), 32'h0);

        // Re-enable: pcnt restarts at 0, ticks at +11, +22, +33; frozen counters 3 and 0.
        cfg_enable = 1'b1;
        f0         = cyc;
        while (cyc < f0 + 32) step();
        check("resume_pre", 32'(debounced), 32'h4);
        step();
        check("resume_deb", 32'(debounced), 32'h1);
        check("resume_rise", 32'(rise_evt), 32'h1);
        check("resume_fall", 32'(fall_evt), 32'h4);
        step();
        check("resume_status", 32'(status), 32'h5);
        step();
        check("resume_irq", 32'(irq), 32'h1);

        // Mid-operation reset with all channels debounced high.
        in_raw = 4'b1111;
        found  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (debounced == 4'b1111) begin
                found = 1'b1;
                break;
            end
        end
        check("all_high", 32'(found), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_debounced", 32'(debounced), 32'h0);
        check("mid_reset_rise", 32'(rise_evt), 32'h0);
        check("mid_reset_fall", 32'(fall_evt), 32'h0);
        check("mid_reset_status", 32'(status), 32'h0);
        check("mid_reset_irq", 32'(irq), 32'h0);
`ifdef VI_DEBOUNCE_CTRL_GLITCH_CNT_EN
        check("mid_reset_glitch", glitch_cnt, 32'h0);
`endif
        bad = 1'b0;
        repeat (3) begin
            step();
            bad |= (|rise_evt) | (|fall_evt) | (|debounced);
        end
        check("post_reset_quiet", 32'(bad), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
